// File: rtl/alt_sync_ram.sv
// True dual-port synchronous RAM on a single clock with registered, old-data reads.
// Port A wins when both ports write the same word on the same edge.
module alt_sync_ram #(
  parameter int NUMWORDS = 1024,
  parameter int WIDTHAD  = 10,
  parameter int WIDTH    = 32
) (
  input  logic               clock0,
  input  logic               reset_n,
  input  logic [WIDTHAD-1:0] address_a,
  input  logic [WIDTH-1:0]   data_a,
  input  logic               wren_a,
  input  logic               rden_a,
  output logic [WIDTH-1:0]   q_a,
  input  logic [WIDTHAD-1:0] address_b,
  input  logic [WIDTH-1:0]   data_b,
  input  logic               wren_b,
  input  logic               rden_b,
  output logic [WIDTH-1:0]   q_b
);

  logic [WIDTH-1:0] mem [NUMWORDS];
  logic             in_range_a;
  logic             in_range_b;
  logic             write_b_ok;

  // When the array fills the whole address space every address is valid.
  generate
    if (NUMWORDS >= (2 ** WIDTHAD)) begin : g_full
      assign in_range_a = 1'b1;
      assign in_range_b = 1'b1;
    end else begin : g_partial
      localparam logic [WIDTHAD-1:0] LAST_ADDR = WIDTHAD'(NUMWORDS - 1);
      assign in_range_a = (address_a <= LAST_ADDR);
      assign in_range_b = (address_b <= LAST_ADDR);
    end
  endgenerate

  assign write_b_ok = wren_b && in_range_b &&
                      !(wren_a && in_range_a && (address_a == address_b));

  // Writes proceed regardless of reset.
  always_ff @(posedge clock0) begin
    if (wren_a && in_range_a) mem[address_a] <= data_a;
    if (write_b_ok)           mem[address_b] <= data_b;
  end

  // Non-blocking reads see the array before this edge's writes.
  always_ff @(posedge clock0) begin
    if (!reset_n) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (rden_a) q_a <= in_range_a ? mem[address_a] : '0;
      if (rden_b) q_b <= in_range_b ? mem[address_b] : '0;
    end
  end

endmodule

// File: tb/tb_alt_sync_ram.sv
// Directed bench for alt_sync_ram: reset, both-port access, collisions, read-enable hold.
module tb_alt_sync_ram;

  logic        clock0;
  logic        reset_n;
  logic [9:0]  address_a;
  logic [31:0] data_a;
  logic        wren_a;
  logic        rden_a;
  logic [31:0] q_a;
  logic [9:0]  address_b;
  logic [31:0] data_b;
  logic        wren_b;
  logic        rden_b;
  logic [31:0] q_b;

  int total = 0;
  int bad   = 0;

  alt_sync_ram dut (
    .clock0    (clock0),
    .reset_n   (reset_n),
    .address_a (address_a),
    .data_a    (data_a),
    .wren_a    (wren_a),
    .rden_a    (rden_a),
    .q_a       (q_a),
    .address_b (address_b),
    .data_b    (data_b),
    .wren_b    (wren_b),
    .rden_b    (rden_b),
    .q_b       (q_b)
  );

  // Clock and reset.
  initial clock0 = 1'b0;
  always #5 clock0 = ~clock0;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clock0);
    #1;
  endtask

  task automatic idle();
    wren_a = 1'b0;
    rden_a = 1'b0;
    wren_b = 1'b0;
    rden_b = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    address_a = '0;
    address_b = '0;
    data_a    = '0;
    data_b    = '0;
    idle();
    step();
    check("reset_q_a", q_a, 32'h0);
    check("reset_q_b", q_b, 32'h0);
    reset_n = 1'b1;

    // Prefill mem[9]=0 and mem[5]=0x12345678.
    wren_a = 1'b1; address_a = 10'd9; data_a = 32'h0;
    wren_b = 1'b1; address_b = 10'd5; data_b = 32'h12345678;
    step();
    idle();
    rden_a = 1'b1; address_a = 10'd5;
    step();
    check("prefill_read", q_a, 32'h12345678);

    // Reset edge: reads discarded, a write still lands.
    reset_n = 1'b0;
    rden_a = 1'b1; address_a = 10'd5;
    rden_b = 1'b1; address_b = 10'd5;
    wren_b = 1'b1; data_b = 32'h00000055;
    address_b = 10'd20;
    step();
    check("rst_mid_q_a", q_a, 32'h0);
    check("rst_mid_q_b", q_b, 32'h0);
    reset_n = 1'b1;
    idle();
    rden_a = 1'b1; address_a = 10'd5;
    rden_b = 1'b1; address_b = 10'd20;
    step();
    check("post_rst_q_a", q_a, 32'h12345678);
    check("rst_write_q_b", q_b, 32'h00000055);

    // Basic writes on both ports to different addresses, then cross reads.
    idle();
    wren_a = 1'b1; address_a = 10'h3FF; data_a = 32'hDEADBEEF;
    wren_b = 1'b1; address_b = 10'h000; data_b = 32'h00000001;
    step();
    check("no_rden_hold_b", q_b, 32'h00000055);
    idle();
    rden_b = 1'b1; address_b = 10'h3FF;
    rden_a = 1'b1; address_a = 10'h000;
    step();
    check("basic_q_b", q_b, 32'hDEADBEEF);
    check("basic_q_a", q_a, 32'h00000001);

    // Mixed-port read during write returns old data.
    idle();
    wren_b = 1'b1; address_b = 10'd7; data_b = 32'hAAAA5555;
    step();
    idle();
    wren_a = 1'b1; address_a = 10'd7; data_a = 32'h11112222;
    rden_b = 1'b1; address_b = 10'd7;
    step();
    check("mixed_old", q_b, 32'hAAAA5555);
    idle();
    rden_b = 1'b1;
    step();
    check("mixed_new", q_b, 32'h11112222);

    // Same-port read during write returns old data.
    idle();
    wren_a = 1'b1; rden_a = 1'b1; address_a = 10'd9; data_a = 32'hCAFEF00D;
    step();
    check("same_old", q_a, 32'h0);
    idle();
    rden_a = 1'b1;
    step();
    check("same_new", q_a, 32'hCAFEF00D);

    // Same-address write collision: port A wins.
    idle();
    wren_a = 1'b1; address_a = 10'd100; data_a = 32'h1;
    wren_b = 1'b1; address_b = 10'd100; data_b = 32'h2;
    step();
    idle();
    rden_a = 1'b1; rden_b = 1'b1;
    step();
    check("collide_q_a", q_a, 32'h1);
    check("collide_q_b", q_b, 32'h1);

    // Read-enable hold.
    idle();
    rden_a = 1'b1; address_a = 10'd5;
    step();
    check("hold_load", q_a, 32'h12345678);
    rden_a = 1'b0; address_a = 10'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_%0d", i), q_a, 32'h12345678);
    end
    rden_a = 1'b1;
    step();
    check("hold_release", q_a, 32'h00000001);

    idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
